level_calibrator: RTL and testbench
===================================

Name: level_calibrator

Overview:
Consumes the one-shot button pulses (reset, save-high, save-low) produced by the front-panel button conditioner. Stores high/low calibration references from the live sensor sample stream and converts each accepted raw sample into a 0–100 % fill level. The conversion uses a multi-cycle restoring divider. Output feeds the display/BCD path.

Parameters:
DATA_W, 12, width of raw sensor sample and calibration references
PCT_MAX, 100, full-scale percentage value; output width fixed at 7 bits
ALARM_LO_PCT, 10, low-level alarm threshold (used only with LEVEL_ALARM_EN)
ALARM_HI_PCT, 90, high-level alarm threshold (used only with LEVEL_ALARM_EN)

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-high reset
reset_button_pulse  in  1  conditioned reset-button pulse; may stay high for several clocks
saveH_pulse  in  1  conditioned save-high pulse; may stay high for several clocks
saveL_pulse  in  1  conditioned save-low pulse; may stay high for several clocks
sample_valid  in  1  one-cycle strobe, sample_data valid
sample_data  in  DATA_W  raw sensor reading
high_ref  out  DATA_W  stored full-level reference
low_ref  out  DATA_W  stored empty-level reference
cal_valid  out  1  high when high_ref > low_ref
cal_error  out  1  high when a save left high_ref <= low_ref
level_pct  out  7  computed level, 0..PCT_MAX
level_valid  out  1  one-cycle strobe, level_pct updated
busy  out  1  high while not in IDLE
alarm_low  out  1  low-level alarm (0 without macro)
alarm_high  out  1  high-level alarm (0 without macro)

Behaviour:
- Reset values: high_ref = all ones, low_ref = 0, cal_valid = 1, cal_error = 0, level_pct = 0, level_valid = 0, busy = 0, alarms = 0, FSM = IDLE, last_sample = 0.
- The three button inputs are internally rising-edge detected. A pulse held for N cycles acts exactly once.
- last_sample register: loaded with sample_data on every sample_valid, in any state.
- Button edge on reset_button_pulse restores the reset values of refs, flags, level_pct and alarms, aborts any conversion, and returns the FSM to IDLE next cycle. It has priority over same-cycle saves.
- saveH edge: high_ref <= last_sample. saveL edge: low_ref <= last_sample. Both edges in the same cycle capture the same value, so cal_error = 1.
- After any save: cal_valid = (high_ref > low_ref), cal_error = !cal_valid. Both are updated one cycle after the edge.
- Save during a conversion: refs update immediately. The in-flight conversion uses its snapshot taken at SUB.
- FSM states: IDLE, SUB, DIV, DONE.
  - IDLE: on sample_valid, or a pending flag, go to SUB and clear pending.
  - SUB: snapshot refs. If !cal_valid, set result 0 and go to DONE. If sample <= low, result 0 and go to DONE. If sample >= high, result PCT_MAX and go to DONE. Otherwise load numerator = (sample − low) × PCT_MAX (DATA_W+7 bits) and divisor = high − low, then go to DIV.
  - DIV: restoring divide, one quotient bit per clock, DATA_W+7 iterations, then go to DONE. Quotient is floor, truncated to 7 bits (always ≤ 99 here).
  - DONE: level_pct <= result, level_valid = 1 for one cycle, go to IDLE.
- Latency from sample_valid accepted in IDLE (cycle 0): clamped or invalid paths give level_valid at cycle 2. Divide path gives level_valid at cycle DATA_W+9 (21 for DATA_W = 12).
- sample_valid while busy sets the pending flag. The newest sample wins; at most one queued conversion.
- Asynchronous reset mid-conversion: all state returns to reset values immediately, and no level_valid is issued.

Optional Feature:
LEVEL_ALARM_EN
- Defined: alarms are evaluated on each DONE, using level_pct with 2 % hysteresis.
  - alarm_low sets when level ≤ ALARM_LO_PCT and clears when level ≥ ALARM_LO_PCT + 2.
  - alarm_high sets when level ≥ ALARM_HI_PCT and clears when level ≤ ALARM_HI_PCT − 2.
  - Alarms are forced to 0 while !cal_valid.
- Undefined: no alarm logic is synthesized, and alarm_low/alarm_high are tied to 0.

Test Plan:
- Sample 1000 then saveL; sample 3000 then saveH; sample 2000 -> low_ref = 1000, high_ref = 3000, cal_valid = 1, level_pct = 50, level_valid exactly 21 cycles after that sample_valid.
- With the same refs, samples 2999, 500 and 3500 -> level_pct 99 (floor), then 0 (valid at cycle 2), then 100 (valid at cycle 2).
- saveH_pulse held high for 50 clocks while last_sample changes from 3000 to 3100 mid-hold -> high_ref = 3000, captured once only.
- saveH and saveL edges in the same cycle with last_sample = 1500 -> both refs 1500, cal_valid = 0, cal_error = 1, next sample gives level_pct = 0 at cycle 2.
- Reset-button edge at cycle 10 of a divide -> no level_valid, refs back to 0 / all ones, level_pct = 0, busy low by cycle 11. Two sample_valids during a divide -> only the second is converted afterwards.
- With LEVEL_ALARM_EN and levels 50, 10, 11, 12 -> alarm_low goes 0, 1, 1, 0. alarm_high stays 0.

Source files
------------

// File: rtl/level_calibrator_if.sv
// ============================================================================
// Module      : level_calibrator_if
// Description : Button, sample and result signals of the level calibrator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface level_calibrator_if #(
   parameter int DATA_W = 12
);
   logic              reset_button_pulse;
   logic              saveH_pulse;
   logic              saveL_pulse;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic [DATA_W-1:0] high_ref;
   logic [DATA_W-1:0] low_ref;
   logic              cal_valid;
   logic              cal_error;
   logic [6:0]        level_pct;
   logic              level_valid;
   logic              busy;
   logic              alarm_low;
   logic              alarm_high;

   modport master (
      output reset_button_pulse, saveH_pulse, saveL_pulse, sample_valid, sample_data,
      input  high_ref, low_ref, cal_valid, cal_error, level_pct, level_valid, busy,
             alarm_low, alarm_high
   );

   modport slave (
      input  reset_button_pulse, saveH_pulse, saveL_pulse, sample_valid, sample_data,
      output high_ref, low_ref, cal_valid, cal_error, level_pct, level_valid, busy,
             alarm_low, alarm_high
   );
endinterface

`default_nettype wire

// File: rtl/level_calibrator.sv
// ============================================================================
// Module      : level_calibrator
// Description : Stores high/low calibration references and converts samples to
//               a 0..PCT_MAX fill level with a restoring divider.
//               Optional LEVEL_ALARM_EN adds hysteretic low/high level alarms.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module level_calibrator #(
   parameter int DATA_W       = 12,
   parameter int PCT_MAX      = 100,
   parameter int ALARM_LO_PCT = 10,
   parameter int ALARM_HI_PCT = 90
) (
   input  logic              clk_100MHz,
   input  logic              reset,
   level_calibrator_if.slave cal
);

   localparam int c_NUM_W = DATA_W + 7;
   localparam int c_CNT_W = $clog2(c_NUM_W);

   typedef enum logic [1:0] {S_IDLE, S_SUB, S_DIV, S_DONE} state_t;

   state_t              r_state;
   logic                r_rst_btn_d, r_save_h_d, r_save_l_d;
   logic [DATA_W-1:0]   r_last_sample, r_high_ref, r_low_ref;
   logic                r_cal_valid, r_cal_error;
   logic [6:0]          r_level_pct;
   logic                r_level_valid;
   logic                r_pending;
   logic [c_NUM_W-1:0]  r_num;
   logic [DATA_W-1:0]   r_den, r_rem;
   logic [5:0]          r_quo;
   logic [c_CNT_W-1:0]  r_cnt;

   logic                w_rst_btn_edge, w_save_h_edge, w_save_l_edge, w_save_any;
   logic [DATA_W-1:0]   w_new_high, w_new_low, w_diff, w_rem_next;
   logic [c_NUM_W-1:0]  w_num_init;
   logic [DATA_W:0]     w_rem_shift;
   logic                w_rem_ge;
   logic [6:0]          w_quo_next, w_result;
   logic                w_finish;

   assign w_rst_btn_edge = cal.reset_button_pulse & ~r_rst_btn_d;
   assign w_save_h_edge  = cal.saveH_pulse & ~r_save_h_d;
   assign w_save_l_edge  = cal.saveL_pulse & ~r_save_l_d;
   assign w_save_any     = w_save_h_edge | w_save_l_edge;
   assign w_new_high     = w_save_h_edge ? r_last_sample : r_high_ref;
   assign w_new_low      = w_save_l_edge ? r_last_sample : r_low_ref;

   assign w_diff      = r_last_sample - r_low_ref;
   assign w_num_init  = c_NUM_W'(w_diff) * c_NUM_W'(PCT_MAX);

   // One restoring step: bring down the next numerator bit, subtract if it fits
   assign w_rem_shift = {r_rem, r_num[c_NUM_W-1]};
   assign w_rem_ge    = (w_rem_shift >= {1'b0, r_den});
   assign w_rem_next  = w_rem_ge ? DATA_W'(w_rem_shift - {1'b0, r_den})
                                 : w_rem_shift[DATA_W-1:0];
   assign w_quo_next  = {r_quo, w_rem_ge};

   always_comb begin
      w_finish = 1'b0;
      w_result = '0;
      case (r_state)
         S_SUB: begin
            if (!r_cal_valid || (r_last_sample <= r_low_ref)) begin
               w_finish = 1'b1;
            end else if (r_last_sample >= r_high_ref) begin
               w_finish = 1'b1;
               w_result = 7'(PCT_MAX);
            end
         end
         S_DIV: begin
            w_finish = (r_cnt == '0);
            w_result = w_quo_next;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_rst_btn_d   <= 1'b0;
         r_save_h_d    <= 1'b0;
         r_save_l_d    <= 1'b0;
         r_last_sample <= '0;
         r_high_ref    <= '1;
         r_low_ref     <= '0;
         r_cal_valid   <= 1'b1;
         r_cal_error   <= 1'b0;
         r_level_pct   <= '0;
         r_level_valid <= 1'b0;
         r_pending     <= 1'b0;
         r_num         <= '0;
         r_den         <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_cnt         <= '0;
      end else begin
         r_rst_btn_d   <= cal.reset_button_pulse;
         r_save_h_d    <= cal.saveH_pulse;
         r_save_l_d    <= cal.saveL_pulse;
         r_level_valid <= 1'b0;
         if (cal.sample_valid) r_last_sample <= cal.sample_data;

         if (w_rst_btn_edge) begin
            r_high_ref  <= '1;
            r_low_ref   <= '0;
            r_cal_valid <= 1'b1;
            r_cal_error <= 1'b0;
            r_level_pct <= '0;
            r_pending   <= 1'b0;
            r_state     <= S_IDLE;
         end else begin
            if (w_save_any) begin
               r_high_ref  <= w_new_high;
               r_low_ref   <= w_new_low;
               r_cal_valid <= (w_new_high > w_new_low);
               r_cal_error <= !(w_new_high > w_new_low);
            end
            if (cal.sample_valid && (r_state != S_IDLE)) r_pending <= 1'b1;

            case (r_state)
               S_IDLE: begin
                  if (cal.sample_valid || r_pending) begin
                     r_state   <= S_SUB;
                     r_pending <= 1'b0;
                  end
               end
               // Divider operands are a snapshot; later saves do not disturb them
               S_SUB: begin
                  r_num   <= w_num_init;
                  r_den   <= r_high_ref - r_low_ref;
                  r_rem   <= '0;
                  r_quo   <= '0;
                  r_cnt   <= c_CNT_W'(c_NUM_W - 1);
                  r_state <= S_DIV;
               end
               S_DIV: begin
                  r_num <= {r_num[c_NUM_W-2:0], 1'b0};
                  r_rem <= w_rem_next;
                  r_quo <= w_quo_next[5:0];
                  r_cnt <= r_cnt - 1'b1;
               end
               S_DONE:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase

            if (w_finish) begin
               r_level_pct   <= w_result;
               r_level_valid <= 1'b1;
               r_state       <= S_DONE;
            end
         end
      end
   end

   assign cal.high_ref    = r_high_ref;
   assign cal.low_ref     = r_low_ref;
   assign cal.cal_valid   = r_cal_valid;
   assign cal.cal_error   = r_cal_error;
   assign cal.level_pct   = r_level_pct;
   assign cal.level_valid = r_level_valid;
   assign cal.busy        = (r_state != S_IDLE);

`ifdef LEVEL_ALARM_EN
   localparam logic [6:0] c_ALO_SET = 7'(ALARM_LO_PCT);
   localparam logic [6:0] c_ALO_CLR = 7'(ALARM_LO_PCT + 2);
   localparam logic [6:0] c_AHI_SET = 7'(ALARM_HI_PCT);
   localparam logic [6:0] c_AHI_CLR = 7'(ALARM_HI_PCT - 2);

   logic r_alarm_low, r_alarm_high;

   // Between the set and clear thresholds each alarm keeps its previous state
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         r_alarm_low  <= 1'b0;
         r_alarm_high <= 1'b0;
      end else if (w_rst_btn_edge || !r_cal_valid) begin
         r_alarm_low  <= 1'b0;
         r_alarm_high <= 1'b0;
      end else if (w_finish) begin
         if (w_result <= c_ALO_SET)      r_alarm_low <= 1'b1;
         else if (w_result >= c_ALO_CLR) r_alarm_low <= 1'b0;
         if (w_result >= c_AHI_SET)      r_alarm_high <= 1'b1;
         else if (w_result <= c_AHI_CLR) r_alarm_high <= 1'b0;
      end
   end

   assign cal.alarm_low  = r_alarm_low & r_cal_valid;
   assign cal.alarm_high = r_alarm_high & r_cal_valid;
`else
   wire w_unused_alarm_cfg = |{7'(ALARM_LO_PCT), 7'(ALARM_HI_PCT)};

   assign cal.alarm_low  = 1'b0;
   assign cal.alarm_high = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_level_calibrator.sv
// ============================================================================
// Module      : tb_level_calibrator
// Description : Self-checking bench for level_calibrator against a percentage model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_level_calibrator;

   localparam int DATA_W = 12;
   localparam int MAXV   = (1 << DATA_W) - 1;

   logic clk_100MHz = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   m_lo, m_hi;

   level_calibrator_if #(.DATA_W(DATA_W)) cal_if ();

   level_calibrator #(.DATA_W(DATA_W)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .cal        (cal_if)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   // Reference model: plain-arithmetic percentage and expected latency
   function automatic int model_level(int s, int lo, int hi);
      if (hi <= lo || s <= lo) return 0;
      if (s >= hi) return 100;
      return ((s - lo) * 100) / (hi - lo);
   endfunction

   function automatic int model_lat(int s, int lo, int hi);
      return (hi <= lo || s <= lo || s >= hi) ? 2 : DATA_W + 9;
   endfunction

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   // Sends one sample from idle and returns the cycle index of level_valid
   task automatic do_sample(input int v, output int lat, output int pct);
      cal_if.sample_valid = 1'b1;
      cal_if.sample_data  = DATA_W'(v);
      tick();
      cal_if.sample_valid = 1'b0;
      lat = 1;
      while (cal_if.level_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      pct = int'(cal_if.level_pct);
      tick();
   endtask

   task automatic pulse_save(input bit h, input bit l);
      cal_if.saveH_pulse = h;
      cal_if.saveL_pulse = l;
      tick();
      cal_if.saveH_pulse = 1'b0;
      cal_if.saveL_pulse = 1'b0;
      tick();
   endtask

   task automatic calibrate(input int lo, input int hi);
      int lat, pct;
      do_sample(lo, lat, pct);
      pulse_save(1'b0, 1'b1);
      do_sample(hi, lat, pct);
      pulse_save(1'b1, 1'b0);
      m_lo = lo;
      m_hi = hi;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cal_if.reset_button_pulse = 1'b0;
      cal_if.saveH_pulse  = 1'b0;
      cal_if.saveL_pulse  = 1'b0;
      cal_if.sample_valid = 1'b0;
      cal_if.sample_data  = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      m_lo = 0;
      m_hi = MAXV;
      checks++; if (cal_if.high_ref !== DATA_W'(MAXV)) begin errors++; $display("FAIL reset_high_ref got %0d expected %0d", cal_if.high_ref, MAXV); end
      checks++; if (cal_if.low_ref !== '0) begin errors++; $display("FAIL reset_low_ref got %0d expected 0", cal_if.low_ref); end
      checks++; if ({cal_if.cal_valid, cal_if.cal_error} !== 2'b10) begin errors++; $display("FAIL reset_cal_flags got %b expected 10", {cal_if.cal_valid, cal_if.cal_error}); end
      checks++; if ({cal_if.level_pct, cal_if.level_valid, cal_if.busy} !== 9'd0) begin errors++; $display("FAIL reset_level got pct=%0d valid=%b busy=%b expected 0/0/0", cal_if.level_pct, cal_if.level_valid, cal_if.busy); end
      checks++; if ({cal_if.alarm_low, cal_if.alarm_high} !== 2'b00) begin errors++; $display("FAIL reset_alarms got %b expected 00", {cal_if.alarm_low, cal_if.alarm_high}); end
   endtask

   task automatic test_basic();
      int lat, pct;
      int vals[4];
      vals = '{2000, 2999, 500, 3500};
      calibrate(1000, 3000);
      checks++; if (cal_if.low_ref !== 12'd1000 || cal_if.high_ref !== 12'd3000) begin errors++; $display("FAIL basic_refs got %0d/%0d expected 1000/3000", cal_if.low_ref, cal_if.high_ref); end
      checks++; if (cal_if.cal_valid !== 1'b1 || cal_if.cal_error !== 1'b0) begin errors++; $display("FAIL basic_cal_valid got %b%b expected 10", cal_if.cal_valid, cal_if.cal_error); end
      for (int i = 0; i < 4; i++) begin
         do_sample(vals[i], lat, pct);
         checks++; if (pct != model_level(vals[i], m_lo, m_hi)) begin errors++; $display("FAIL basic_pct sample=%0d got %0d expected %0d", vals[i], pct, model_level(vals[i], m_lo, m_hi)); end
         checks++; if (lat != model_lat(vals[i], m_lo, m_hi)) begin errors++; $display("FAIL basic_latency sample=%0d got %0d expected %0d", vals[i], lat, model_lat(vals[i], m_lo, m_hi)); end
         checks++; if (cal_if.level_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width got %b expected 0", cal_if.level_valid); end
      end
   endtask

   task automatic test_hold_save();
      int lat, pct;
      do_sample(3000, lat, pct);
      cal_if.saveH_pulse = 1'b1;
      repeat (20) tick();
      cal_if.sample_valid = 1'b1;
      cal_if.sample_data  = 12'd3100;
      tick();
      cal_if.sample_valid = 1'b0;
      repeat (29) tick();
      cal_if.saveH_pulse = 1'b0;
      tick();
      checks++; if (cal_if.high_ref !== 12'd3000) begin errors++; $display("FAIL hold_save_high_ref got %0d expected 3000", cal_if.high_ref); end
      do_sample(2000, lat, pct);
      checks++; if (pct != model_level(2000, m_lo, m_hi)) begin errors++; $display("FAIL hold_save_pct got %0d expected %0d", pct, model_level(2000, m_lo, m_hi)); end
   endtask

   task automatic test_same_cycle_save();
      int lat, pct;
      do_sample(1500, lat, pct);
      pulse_save(1'b1, 1'b1);
      checks++; if (cal_if.low_ref !== 12'd1500 || cal_if.high_ref !== 12'd1500) begin errors++; $display("FAIL dual_save_refs got %0d/%0d expected 1500/1500", cal_if.low_ref, cal_if.high_ref); end
      checks++; if (cal_if.cal_valid !== 1'b0 || cal_if.cal_error !== 1'b1) begin errors++; $display("FAIL dual_save_flags got %b%b expected 01", cal_if.cal_valid, cal_if.cal_error); end
      do_sample(2000, lat, pct);
      checks++; if (pct != model_level(2000, 1500, 1500) || lat != model_lat(2000, 1500, 1500)) begin errors++; $display("FAIL dual_save_level got pct=%0d lat=%0d expected %0d/%0d", pct, lat, model_level(2000, 1500, 1500), model_lat(2000, 1500, 1500)); end
      calibrate(1000, 3000);
      checks++; if (cal_if.cal_valid !== 1'b1 || cal_if.cal_error !== 1'b0) begin errors++; $display("FAIL recal_flags got %b%b expected 10", cal_if.cal_valid, cal_if.cal_error); end
   endtask

   task automatic test_reset_button();
      int lat, pct, seen;
      do_sample(2500, lat, pct);
      cal_if.sample_valid = 1'b1;
      cal_if.sample_data  = 12'd2000;
      tick();
      cal_if.sample_valid = 1'b0;
      repeat (9) tick();
      checks++; if (cal_if.busy !== 1'b1) begin errors++; $display("FAIL btn_busy_before got %b expected 1", cal_if.busy); end
      cal_if.reset_button_pulse = 1'b1;
      tick();
      m_lo = 0;
      m_hi = MAXV;
      checks++; if (cal_if.busy !== 1'b0) begin errors++; $display("FAIL btn_busy_after got %b expected 0", cal_if.busy); end
      checks++; if (cal_if.high_ref !== DATA_W'(MAXV) || cal_if.low_ref !== '0) begin errors++; $display("FAIL btn_refs got %0d/%0d expected 0/%0d", cal_if.low_ref, cal_if.high_ref, MAXV); end
      checks++; if (cal_if.level_pct !== 7'd0 || cal_if.cal_valid !== 1'b1 || cal_if.cal_error !== 1'b0) begin errors++; $display("FAIL btn_state got pct=%0d flags=%b%b expected 0/10", cal_if.level_pct, cal_if.cal_valid, cal_if.cal_error); end
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 5) cal_if.reset_button_pulse = 1'b0;
         if (cal_if.level_valid === 1'b1) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL btn_no_level_valid got %0d pulses expected 0", seen); end
      do_sample(2000, lat, pct);
      checks++; if (pct != model_level(2000, m_lo, m_hi) || lat != model_lat(2000, m_lo, m_hi)) begin errors++; $display("FAIL btn_default_refs got pct=%0d lat=%0d expected %0d/%0d", pct, lat, model_level(2000, m_lo, m_hi), model_lat(2000, m_lo, m_hi)); end
   endtask

   task automatic test_back_to_back();
      int got[$];
      int first_cyc, second;
      calibrate(1000, 3000);
      first_cyc = -1;
      for (int cyc = 0; cyc < 70; cyc++) begin
         cal_if.sample_valid = (cyc == 0 || cyc == 5 || cyc == 8);
         cal_if.sample_data  = (cyc == 0) ? 12'd2000 : (cyc == 5) ? 12'd1500 : 12'd2500;
         tick();
         if (cal_if.level_valid === 1'b1) begin
            got.push_back(int'(cal_if.level_pct));
            if (first_cyc < 0) first_cyc = cyc + 1;
         end
      end
      cal_if.sample_valid = 1'b0;
      second = (got.size() > 1) ? got[1] : -1;
      checks++; if (got.size() != 2) begin errors++; $display("FAIL b2b_count got %0d expected 2", got.size()); end
      checks++; if (first_cyc != DATA_W + 9) begin errors++; $display("FAIL b2b_first_latency got %0d expected %0d", first_cyc, DATA_W + 9); end
      checks++; if (second != model_level(2500, m_lo, m_hi)) begin errors++; $display("FAIL b2b_second_pct got %0d expected %0d", second, model_level(2500, m_lo, m_hi)); end
   endtask

   task automatic test_async_reset();
      int seen;
      cal_if.sample_valid = 1'b1;
      cal_if.sample_data  = 12'd2000;
      tick();
      cal_if.sample_valid = 1'b0;
      repeat (5) tick();
      #2;
      reset = 1'b1;
      #1;
      m_lo = 0;
      m_hi = MAXV;
      checks++; if (cal_if.busy !== 1'b0 || cal_if.high_ref !== DATA_W'(MAXV) || cal_if.low_ref !== '0) begin errors++; $display("FAIL async_reset got busy=%b refs=%0d/%0d expected 0 0/%0d", cal_if.busy, cal_if.low_ref, cal_if.high_ref, MAXV); end
      tick();
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (cal_if.level_valid === 1'b1) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL async_no_level_valid got %0d pulses expected 0", seen); end
   endtask

   task automatic test_random();
      int lat, pct, s, lo, hi;
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 0) begin
            lo = $urandom_range(0, 3000);
            if ($urandom_range(0, 4) == 0) hi = $urandom_range(0, lo);
            else                            hi = $urandom_range(lo + 1, MAXV);
            calibrate(lo, hi);
            checks++; if (cal_if.low_ref !== DATA_W'(lo) || cal_if.high_ref !== DATA_W'(hi)) begin errors++; $display("FAIL rand_refs got %0d/%0d expected %0d/%0d", cal_if.low_ref, cal_if.high_ref, lo, hi); end
            checks++; if (cal_if.cal_valid !== (hi > lo) || cal_if.cal_error !== !(hi > lo)) begin errors++; $display("FAIL rand_cal_flags got %b%b expected %b%b", cal_if.cal_valid, cal_if.cal_error, hi > lo, !(hi > lo)); end
         end
         s = $urandom_range(0, MAXV);
         do_sample(s, lat, pct);
         checks++; if (pct != model_level(s, m_lo, m_hi) || lat != model_lat(s, m_lo, m_hi)) begin errors++; $display("FAIL rand_level s=%0d lo=%0d hi=%0d got pct=%0d lat=%0d expected %0d/%0d", s, m_lo, m_hi, pct, lat, model_level(s, m_lo, m_hi), model_lat(s, m_lo, m_hi)); end
`ifndef LEVEL_ALARM_EN
         checks++; if ({cal_if.alarm_low, cal_if.alarm_high} !== 2'b00) begin errors++; $display("FAIL rand_alarms_tied got %b expected 00", {cal_if.alarm_low, cal_if.alarm_high}); end
`endif
      end
   endtask

`ifdef LEVEL_ALARM_EN
   task automatic test_alarm();
      int lat, pct;
      int smp[7];
      bit exp_lo[7];
      bit exp_hi[7];
      smp    = '{2000, 1200, 1220, 1240, 2800, 2780, 2760};
      exp_lo = '{0, 1, 1, 0, 0, 0, 0};
      exp_hi = '{0, 0, 0, 0, 1, 1, 0};
      calibrate(1000, 3000);
      for (int i = 0; i < 7; i++) begin
         do_sample(smp[i], lat, pct);
         checks++; if (cal_if.alarm_low !== exp_lo[i] || cal_if.alarm_high !== exp_hi[i]) begin errors++; $display("FAIL alarm level=%0d got lo=%b hi=%b expected lo=%b hi=%b", pct, cal_if.alarm_low, cal_if.alarm_high, exp_lo[i], exp_hi[i]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_hold_save();
      test_same_cycle_save();
      test_reset_button();
      test_back_to_back();
      test_async_reset();
      test_random();
`ifdef LEVEL_ALARM_EN
      test_alarm();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
